// File: rtl/ecc_rom_pkg.sv
// Shared ROM-side constants and the operand loader state encoding.
package ecc_rom_pkg;

    localparam int unsigned ROM_AW = 7;
    localparam int unsigned ROM_DW = 16;
    localparam logic [ROM_AW-1:0] PARK_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/rom_operand_loader.sv
// Burst sequencer in front of rominterface: fetches a run of ROM words and
// packs them MSW-first into one wide operand, with a per-word watchdog.
module rom_operand_loader
    import ecc_rom_pkg::*;
#(
    parameter int unsigned       MAX_WORDS = 11,
    parameter logic [ROM_AW-1:0] PARK_ADDR = ecc_rom_pkg::PARK_ADDR,
    parameter int unsigned       TIMEOUT   = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic [ROM_AW-1:0]           i_base_addr,
    input  logic [7:0]                  i_nwords,
    output logic                        o_busy,
    output logic [ROM_DW*MAX_WORDS-1:0] o_operand,
    output logic                        o_operand_vld,
    output logic                        o_err,
    output logic                        o_rd_rom,
    output logic                        o_wr_rom,
    output logic [ROM_AW-1:0]           o_addr_rom,
    output logic [7:0]                  o_wordcnt_rom,
    input  logic                        i_word_vld,
    input  logic                        i_word_done,
    input  logic [ROM_DW-1:0]           i_word
);

    localparam int unsigned OPW = ROM_DW * MAX_WORDS;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    loader_state_t     r_state;
    logic [ROM_AW-1:0] r_addr;
    logic [7:0]        r_rem;
    logic [7:0]        r_wordcnt;
    logic              r_rd;
    logic [OPW-1:0]    r_operand;
    logic              r_vld;
    logic              r_err;
    logic              r_busy;
    logic [TW-1:0]     r_tcnt;

    logic [8:0]        w_end;
    logic              w_bad_args;
    logic              w_fault;

    // base + nwords > PARK is the same test as last address >= PARK, without the -1
    assign w_end      = {2'b00, i_base_addr} + {1'b0, i_nwords};
    assign w_bad_args = (i_nwords == 8'd0) || (i_nwords > 8'(MAX_WORDS))
                        || (w_end > {2'b00, PARK_ADDR});

    // Handshake mismatch on a delivered word, or the watchdog expiring
    assign w_fault = (r_state == LOAD) &&
                     (i_word_vld ? ((r_rem > 8'd1) ? i_word_done : !i_word_done)
                                 : (r_tcnt == TW'(TIMEOUT - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= PARK_ADDR;
            r_rem     <= '0;
            r_wordcnt <= '0;
            r_rd      <= 1'b0;
            r_operand <= '0;
            r_vld     <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_tcnt    <= '0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_addr <= PARK_ADDR;
                    r_rd   <= 1'b0;
                    r_tcnt <= '0;
                    if (i_start) begin
                        if (w_bad_args) begin
                            r_err <= 1'b1;
                        end else begin
                            r_operand <= '0;
                            r_addr    <= i_base_addr;
                            r_rem     <= i_nwords;
                            r_wordcnt <= i_nwords;
                            r_rd      <= 1'b1;
                            r_err     <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (w_fault) begin
                        r_err     <= 1'b1;
                        r_rd      <= 1'b0;
                        r_addr    <= PARK_ADDR;
                        r_wordcnt <= '0;
                        r_busy    <= 1'b0;
                        r_tcnt    <= '0;
                        r_state   <= ERR;
                    end else if (i_word_vld) begin
                        r_operand <= {r_operand[OPW-ROM_DW-1:0], i_word};
                        r_tcnt    <= '0;
                        if (r_rem > 8'd1) begin
                            r_addr    <= r_addr + 1'b1;
                            r_rem     <= r_rem - 1'b1;
                            r_wordcnt <= r_wordcnt - 1'b1;
                        end else begin
                            r_vld   <= 1'b1;
                            r_state <= DONE;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                DONE: begin
                    r_rd      <= 1'b0;
                    r_addr    <= PARK_ADDR;
                    r_wordcnt <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                ERR: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_operand     = r_operand;
    assign o_operand_vld = r_vld;
    assign o_err         = r_err;
    assign o_rd_rom      = r_rd;
    assign o_wr_rom      = 1'b0;
    assign o_addr_rom    = r_addr;
    assign o_wordcnt_rom = r_wordcnt;

endmodule
